bcd_serial_addsub: RTL and testbench

//  Multi-digit BCD adder/subtractor that feeds one BCD digit per clock into a

---
 rtl/bcd_serial_addsub_pkg.sv | 18 +
 rtl/bcd_serial_addsub_if.sv | 24 ++
 rtl/bcd_digit_adder.sv | 17 +
 rtl/bcd_serial_addsub.sv | 115 +++++++++++
 tb/tb_bcd_serial_addsub.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_serial_addsub_pkg.sv
// Shared definitions for the serial BCD add/subtract datapath:
// digit limit, FSM states and the 9's-complement helper.
package bcd_serial_addsub_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Start/busy/done handshake and packed-BCD operand/result bus.
interface bcd_serial_addsub_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  invalid;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, invalid
    );
endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal-carry correction.
module bcd_digit_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] z;
    logic       corr;

    assign z    = 5'(x) + 5'(y) + 5'(cin);
    // Binary sum above 9 needs +6 to wrap back into BCD and raise the carry
    assign corr = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
    assign s    = z[3:0] + {corr, corr, 1'b0};
    assign cout = corr;
endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD adder/subtractor: one digit per clock through a shared
// digit adder, decimal carry rippled through a register.
module bcd_serial_addsub
    import bcd_serial_addsub_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_serial_addsub_if.slave    bus
);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t            state;
    logic [IW-1:0]     idx;
    logic              carry;
    logic [3:0]        a_q   [DIGITS];
    logic [3:0]        b_q   [DIGITS];
    logic [3:0]        sum_q [DIGITS];
    logic              busy_q;
    logic              done_q;
    logic              cout_q;
    logic              invalid_q;

    logic [3:0]        dsum;
    logic              dcarry;
    logic              bad_c;

    bcd_digit_adder u_digit (
        .x    (a_q[idx]),
        .y    (b_q[idx]),
        .cin  (carry),
        .s    (dsum),
        .cout (dcarry)
    );

    // Any raw operand digit outside 0..9 makes the request invalid
    always_comb begin
        bad_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.a[4*i +: 4] > BCD_MAX || bus.b[4*i +: 4] > BCD_MAX) begin
                bad_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    // The done cycle is spent in IDLE; a start seen there waits one more cycle
                    if (bus.start && !done_q) begin
                        busy_q    <= 1'b1;
                        idx       <= '0;
                        carry     <= bus.sub;
                        cout_q    <= 1'b0;
                        invalid_q <= 1'b0;
                        for (int unsigned i = 0; i < DIGITS; i++) begin
                            a_q[i]   <= bus.a[4*i +: 4];
                            b_q[i]   <= bus.sub ? nines(bus.b[4*i +: 4]) : bus.b[4*i +: 4];
                            sum_q[i] <= '0;
                        end
                        if (bad_c) begin
                            invalid_q <= 1'b1;
                            state     <= FIN;
                        end else begin
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    sum_q[idx] <= dsum;
                    carry      <= dcarry;
                    if (idx == LAST_IDX) begin
                        cout_q <= dcarry;
                        state  <= FIN;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                FIN: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_sum
        assign bus.sum[4*g +: 4] = sum_q[g];
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cout    = cout_q;
    assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub: directed cases plus randomized
// operations against an integer-arithmetic reference model.
module tb_bcd_serial_addsub;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned W = 4 * DIGITS;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decode to integers, do decimal arithmetic, re-encode
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] es, output logic ec, output logic ei);
        int av, bv, r, lim;
        av = 0; bv = 0; lim = 1; ei = 1'b0; es = '0; ec = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) ei = 1'b1;
            av = av * 10 + int'(a[4*i +: 4]);
            bv = bv * 10 + int'(b[4*i +: 4]);
            lim = lim * 10;
        end
        if (ei) return;
        if (!s) begin
            r  = av + bv;
            ec = (r >= lim);
            r  = r % lim;
        end else if (av >= bv) begin
            r  = av - bv;
            ec = 1'b1;
        end else begin
            r  = lim - (bv - av);
            ec = 1'b0;
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            es[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endtask

    // Issue one request, return the result and edges from acceptance to done
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] rs, output logic rc, output logic ri,
                          output int lat, output logic busy0);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sub = s; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy0 = bus.busy;
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        rs = bus.sum; rc = bus.cout; ri = bus.invalid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 ||
            bus.cout !== 1'b0 || bus.invalid !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b invalid=%b, expected all zero",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.invalid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'h0347, 16'h9999, 16'h0500, 16'h0123};
        logic [W-1:0] vb [4] = '{16'h0285, 16'h0001, 16'h0123, 16'h0500};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] xs [4] = '{16'h0632, 16'h0000, 16'h0377, 16'h9623};
        logic         xc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] rs;
        logic rc, ri, b0;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vs[i], rs, rc, ri, lat, b0);
            checks++;
            if (rs !== xs[i] || rc !== xc[i] || ri !== 1'b0) begin
                errors++;
                $display("FAIL directed[%0d]: got sum=%h cout=%b inv=%b, expected sum=%h cout=%b inv=0",
                         i, rs, rc, ri, xs[i], xc[i]);
            end
            checks++;
            if (lat != int'(DIGITS) + 1 || b0 !== 1'b1) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got lat=%0d busy=%b, expected lat=%0d busy=1",
                         i, lat, b0, DIGITS + 1);
            end
        end
    endtask

    task automatic test_invalid();
        logic [W-1:0] rs;
        logic rc, ri, b0;
        int lat;
        // Prior op leaves cout=1 so the clear on an invalid request is observable
        run_op(16'h9999, 16'h0001, 1'b0, rs, rc, ri, lat, b0);
        run_op(16'h00A0, W'($urandom_range(16'h9999, 0)), 1'b0, rs, rc, ri, lat, b0);
        checks++;
        if (rs !== '0 || rc !== 1'b0 || ri !== 1'b1 || lat != 1) begin
            errors++;
            $display("FAIL invalid_a: got sum=%h cout=%b inv=%b lat=%0d, expected sum=0000 cout=0 inv=1 lat=1",
                     rs, rc, ri, lat);
        end
        run_op(16'h1234, 16'hF000, 1'b1, rs, rc, ri, lat, b0);
        checks++;
        if (rs !== '0 || rc !== 1'b0 || ri !== 1'b1 || lat != 1) begin
            errors++;
            $display("FAIL invalid_b: got sum=%h cout=%b inv=%b lat=%0d, expected sum=0000 cout=0 inv=1 lat=1",
                     rs, rc, ri, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, rs, es;
        logic s, rc, ri, ec, ei, b0;
        int lat, elat;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                a[4*i +: 4] = 4'($urandom_range(9, 0));
                b[4*i +: 4] = 4'($urandom_range(9, 0));
            end
            if ($urandom_range(9, 0) == 0) begin
                if ($urandom_range(1, 0) == 1) a[4*$urandom_range(DIGITS-1, 0) +: 4] = 4'($urandom_range(15, 10));
                else                           b[4*$urandom_range(DIGITS-1, 0) +: 4] = 4'($urandom_range(15, 10));
            end
            s = 1'($urandom_range(1, 0));
            model(a, b, s, es, ec, ei);
            elat = ei ? 1 : int'(DIGITS) + 1;
            run_op(a, b, s, rs, rc, ri, lat, b0);
            checks++;
            if (rs !== es || rc !== ec || ri !== ei || lat != elat) begin
                errors++;
                $display("FAIL random[%0d] %h %s %h: got sum=%h cout=%b inv=%b lat=%0d, expected sum=%h cout=%b inv=%b lat=%0d",
                         n, a, s ? "-" : "+", b, rs, rc, ri, lat, es, ec, ei, elat);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clk);
        bus.a = 16'h0347; bus.b = 16'h0285; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int k = 2; k <= 64; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (bus.sum !== 16'h0632 || bus.cout !== 1'b0 || lat != int'(DIGITS) + 1) begin
            errors++;
            $display("FAIL ignore_busy: got sum=%h cout=%b lat=%0d, expected sum=0632 cout=0 lat=%0d",
                     bus.sum, bus.cout, lat, DIGITS + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bus.a = 16'h0347; bus.b = 16'h0285; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 16'h0500; bus.b = 16'h0123; bus.sub = 1'b1;
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (bus.sum !== 16'h0632 || bus.cout !== 1'b0 || lat != int'(DIGITS) + 1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got sum=%h cout=%b lat=%0d busy=%b, expected sum=0632 cout=0 lat=%0d busy=1",
                     bus.sum, bus.cout, lat, DIGITS + 1, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got busy=%b done=%b, expected busy=0 done=0", bus.busy, bus.done);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b, expected busy=1", bus.busy);
        end
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (bus.sum !== 16'h0377 || bus.cout !== 1'b1 || lat != int'(DIGITS) + 1) begin
            errors++;
            $display("FAIL b2b_second: got sum=%h cout=%b lat=%0d, expected sum=0377 cout=1 lat=%0d",
                     bus.sum, bus.cout, lat, DIGITS + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] rs;
        logic rc, ri, b0, saw;
        int lat;
        @(negedge clk);
        bus.a = 16'h0347; bus.b = 16'h0285; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.sum !== 16'h0032 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_partial: got sum=%h busy=%b, expected sum=0032 busy=1", bus.sum, bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0 ||
            bus.cout !== 1'b0 || bus.invalid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b inv=%b, expected all zero",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.invalid);
        end
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < int'(DIGITS) + 3; k++) begin
            @(posedge clk); #1;
            if (bus.done) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL midrun_nodone: got done pulse after abort, expected none");
        end
        run_op(16'h0001, 16'h0001, 1'b0, rs, rc, ri, lat, b0);
        checks++;
        if (rs !== 16'h0002 || rc !== 1'b0 || ri !== 1'b0 || lat != int'(DIGITS) + 1) begin
            errors++;
            $display("FAIL post_reset_op: got sum=%h cout=%b inv=%b lat=%0d, expected sum=0002 cout=0 inv=0 lat=%0d",
                     rs, rc, ri, lat, DIGITS + 1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_invalid();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
